// File: rtl/hdmi_period_scheduler_if.sv
// Scheduler-side bundle for the HDMI period scheduler: the packet-ready input
// plus the per-pixel period selection, control bits and raster position.
interface hdmi_period_scheduler_if;
  logic        pkt_valid;
  logic [2:0]  mode;
  logic [5:0]  ctrl;
  logic        pkt_ack;
  logic [4:0]  pkt_idx;
  logic [10:0] cx;
  logic [9:0]  cy;

  modport master (
    input  pkt_valid,
    output mode, ctrl, pkt_ack, pkt_idx, cx, cy
  );

  modport slave (
    output pkt_valid,
    input  mode, ctrl, pkt_ack, pkt_idx, cx, cy
  );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// HDMI TMDS period scheduler: walks the raster and, for every pixel, selects
// control / video preamble / video guard / video, and (when the macro
// HDMI_DATA_ISLAND_EN is defined) one 32-character data island per line.
// Without HDMI_DATA_ISLAND_EN the block is a plain DVI scheduler.
// Every output is registered and describes the cx/cy presented with it.
module hdmi_period_scheduler #(
  parameter int   H_ACTIVE     = 1280,
  parameter int   H_TOTAL      = 1650,
  parameter int   H_SYNC_START = 1390,
  parameter int   H_SYNC_END   = 1430,
  parameter int   V_ACTIVE     = 720,
  parameter int   V_TOTAL      = 750,
  parameter int   V_SYNC_START = 725,
  parameter int   V_SYNC_END   = 730,
  parameter logic SYNC_POL     = 1'b1
) (
  input logic                     clk_pixel,
  input logic                     reset,
  hdmi_period_scheduler_if.master bus
);

  // An island (12 lead-in + 44 island cycles after the active region) must
  // finish before the video preamble of the next line begins.
  if (H_ACTIVE + 12 + 44 + 12 > H_TOTAL - 10) begin : g_bad_timing
    $error("hdmi_period_scheduler: data island overlaps the video preamble");
  end

  localparam logic [10:0] HA      = 11'(H_ACTIVE);
  localparam logic [10:0] HT_M1   = 11'(H_TOTAL - 1);
  localparam logic [10:0] PRE_LO  = 11'(H_TOTAL - 10);
  localparam logic [10:0] PRE_HI  = 11'(H_TOTAL - 3);
  localparam logic [10:0] GRD_LO  = 11'(H_TOTAL - 2);
  localparam logic [10:0] HS_LO   = 11'(H_SYNC_START);
  localparam logic [10:0] HS_HI   = 11'(H_SYNC_END);
  localparam logic [9:0]  VA      = 10'(V_ACTIVE);
  localparam logic [9:0]  VT_M1   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_LO   = 10'(V_SYNC_START);
  localparam logic [9:0]  VS_HI   = 10'(V_SYNC_END);

  localparam logic [2:0] MODE_CTRL   = 3'd0;
  localparam logic [2:0] MODE_VIDEO  = 3'd1;
  localparam logic [2:0] MODE_VGUARD = 3'd2;
  localparam logic [2:0] MODE_ISLAND = 3'd3;
  localparam logic [2:0] MODE_IGUARD = 3'd4;

  typedef enum logic [2:0] {
    ST_CTRL,
    ST_VID_PRE,
    ST_VID_GUARD,
    ST_VIDEO
`ifdef HDMI_DATA_ISLAND_EN
    ,
    ST_DI_PRE,
    ST_DI_GL,
    ST_DI_DATA,
    ST_DI_GT
`endif
  } state_t;

  logic        run;      // low until the first edge after reset: that edge shows cx=0 again
  state_t      nxt_st;
  logic [10:0] nx;
  logic [9:0]  ny;
  logic [9:0]  nl;       // line following ny, used to see whether video comes next
  logic        hs;
  logic        vs;

  // Raster position and sync levels for the cycle about to be presented.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    nx = '0;
    ny = '0;
    if (run) begin
      if (bus.cx == HT_M1) begin
        nx = '0;
        ny = (bus.cy == VT_M1) ? '0 : bus.cy + 10'd1;
      end else begin
        nx = bus.cx + 11'd1;
        ny = bus.cy;
      end
    end
    nl = (ny == VT_M1) ? '0 : ny + 10'd1;
    hs = (nx >= HS_LO && nx < HS_HI) ? SYNC_POL : ~SYNC_POL;
    vs = (ny >= VS_LO && ny < VS_HI) ? SYNC_POL : ~SYNC_POL;
  end

`ifdef HDMI_DATA_ISLAND_EN
  // Island sequencing: 0..7 preamble, 8..9 leading guard, 10..41 data, 42..43 trailing guard.
  localparam logic [5:0] CNT_GL   = 6'd8;
  localparam logic [5:0] CNT_DATA = 6'd10;
  localparam logic [5:0] CNT_GT   = 6'd42;
  localparam logic [5:0] CNT_LAST = 6'd43;
  localparam logic [10:0] DECIDE  = 11'(H_ACTIVE + 11);

  state_t     st;
  logic [5:0] isl_cnt;
  logic [5:0] nxt_cnt;
  logic       in_island;

  assign in_island = (st == ST_DI_PRE) || (st == ST_DI_GL) ||
                     (st == ST_DI_DATA) || (st == ST_DI_GT);
`endif

  // Period selection for the next pixel; a running island overrides the raster rules.
  always_comb begin
    nxt_st = ST_CTRL;
    if (ny < VA && nx < HA)
      nxt_st = ST_VIDEO;
    else if (nl < VA && nx >= PRE_LO && nx <= PRE_HI)
      nxt_st = ST_VID_PRE;
    else if (nl < VA && nx >= GRD_LO)
      nxt_st = ST_VID_GUARD;
`ifdef HDMI_DATA_ISLAND_EN
    nxt_cnt = '0;
    if (in_island && isl_cnt != CNT_LAST) begin
      nxt_cnt = isl_cnt + 6'd1;
      if (nxt_cnt < CNT_GL)        nxt_st = ST_DI_PRE;
      else if (nxt_cnt < CNT_DATA) nxt_st = ST_DI_GL;
      else if (nxt_cnt < CNT_GT)   nxt_st = ST_DI_DATA;
      else                         nxt_st = ST_DI_GT;
    end else if (run && bus.cx == DECIDE && bus.pkt_valid) begin
      nxt_st = ST_DI_PRE;
    end
`endif
  end

  // Register the raster position and the outputs decoded from the chosen period.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      run       <= 1'b0;
      bus.cx    <= '0;
      bus.cy    <= '0;
      bus.mode  <= MODE_CTRL;
      bus.ctrl  <= {4'b0000, ~SYNC_POL, ~SYNC_POL};
`ifdef HDMI_DATA_ISLAND_EN
      st          <= ST_CTRL;
      isl_cnt     <= '0;
      bus.pkt_ack <= 1'b0;
      bus.pkt_idx <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      run           <= 1'b1;
      bus.cx        <= nx;
      bus.cy        <= ny;
      bus.ctrl[1:0] <= {vs, hs};
      case (nxt_st)
        ST_VIDEO:     begin bus.mode <= MODE_VIDEO;  bus.ctrl[5:2] <= 4'b0000; end
        ST_VID_PRE:   begin bus.mode <= MODE_CTRL;   bus.ctrl[5:2] <= 4'b0001; end
        ST_VID_GUARD: begin bus.mode <= MODE_VGUARD; bus.ctrl[5:2] <= 4'b0000; end
`ifdef HDMI_DATA_ISLAND_EN
        ST_DI_PRE:    begin bus.mode <= MODE_CTRL;   bus.ctrl[5:2] <= 4'b0101; end
        ST_DI_GL,
        ST_DI_GT:     begin bus.mode <= MODE_IGUARD; bus.ctrl[5:2] <= 4'b0000; end
        ST_DI_DATA:   begin bus.mode <= MODE_ISLAND; bus.ctrl[5:2] <= 4'b0000; end
`endif
        default:      begin bus.mode <= MODE_CTRL;   bus.ctrl[5:2] <= 4'b0000; end
      endcase
`ifdef HDMI_DATA_ISLAND_EN
      st          <= nxt_st;
      isl_cnt     <= nxt_cnt;
      bus.pkt_ack <= (nxt_st == ST_DI_DATA) && (nxt_cnt == CNT_DATA);
      bus.pkt_idx <= (nxt_st == ST_DI_DATA) ? 5'(nxt_cnt - CNT_DATA) : 5'd0;
`endif
    end
  end

`ifdef HDMI_DATA_ISLAND_EN
`else
  // DVI build: no islands, so the packet handshake is idle.
  assign bus.pkt_ack = 1'b0;
  assign bus.pkt_idx = '0;
`endif

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler on a tiny 100x4 raster.
// Expectations follow whichever build HDMI_DATA_ISLAND_EN selects.
module tb_hdmi_period_scheduler;
  logic clk_pixel = 1'b0;
  logic reset;

  hdmi_period_scheduler_if bus ();

  hdmi_period_scheduler #(
    .H_ACTIVE(16), .H_TOTAL(100), .H_SYNC_START(80), .H_SYNC_END(84),
    .V_ACTIVE(2), .V_TOTAL(4), .V_SYNC_START(2), .V_SYNC_END(3), .SYNC_POL(1'b1)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

`ifdef HDMI_DATA_ISLAND_EN
  localparam bit ISL = 1'b1;
`else
  localparam bit ISL = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s (cx=%0d cy=%0d): got %0h expected %0h", tag, bus.cx, bus.cy, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(negedge clk_pixel);
  endtask

  // Advance (bounded) to a raster position; a timeout shows up as a failed position check.
  task automatic wait_pos(input int x, input int y);
    for (int i = 0; i < 2000; i++) begin
      if (bus.cx == x && bus.cy == y) break;
      tick();
    end
    check("wait_cx", 32'(bus.cx), x);
    check("wait_cy", 32'(bus.cy), y);
  endtask

  // Run an island-request line from cx 28 through 72 and compare against the expected schedule.
  task automatic check_island_line();
    logic [2:0] e_mode;
    logic [3:0] e_ctl;
    logic       e_ack;
    logic [4:0] e_idx;
    for (int c = 28; c <= 72; c++) begin
      e_mode = 3'd0; e_ctl = 4'b0000; e_ack = 1'b0; e_idx = 5'd0;
      if (ISL) begin
        if (c <= 35)      e_ctl = 4'b0101;
        else if (c <= 37) e_mode = 3'd4;
        else if (c <= 69) begin e_mode = 3'd3; e_idx = 5'(c - 38); e_ack = (c == 38); end
        else if (c <= 71) e_mode = 3'd4;
      end
      check("isl_mode", bus.mode, e_mode);
      check("isl_ctrl", bus.ctrl, {e_ctl, 2'b00});
      check("isl_ack",  bus.pkt_ack, e_ack);
      check("isl_idx",  bus.pkt_idx, e_idx);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.pkt_valid = 1'b0;
    #13;
    check("rst_cx",   bus.cx, 0);
    check("rst_cy",   bus.cy, 0);
    check("rst_mode", bus.mode, 0);
    check("rst_ctrl", bus.ctrl, 0);
    check("rst_ack",  bus.pkt_ack, 0);
    check("rst_idx",  bus.pkt_idx, 0);

    // First cycle after release repeats cx=0 and is video.
    tick();
    reset = 1'b0;
    tick();
    check("rel_cx",   bus.cx, 0);
    check("rel_cy",   bus.cy, 0);
    check("rel_mode", bus.mode, 1);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("vid_cx",   bus.cx, i);
      check("vid_mode", bus.mode, 1);
    end
    tick();
    check("blank16_mode", bus.mode, 0);

    // No request: no island on line 0.
    wait_pos(28, 0);
    check("noreq_mode", bus.mode, 0);
    check("noreq_ctrl", bus.ctrl, 0);

    // Video preamble and guard ahead of active line 1.
    wait_pos(90, 0);
    for (int i = 90; i < 98; i++) begin
      check("vpre_ctl",  bus.ctrl[5:2], 4'b0001);
      check("vpre_mode", bus.mode, 0);
      tick();
    end
    check("vgrd98_mode", bus.mode, 2);
    tick();
    check("vgrd99_mode", bus.mode, 2);
    tick();
    check("l1_cx", bus.cx, 0);
    check("l1_cy", bus.cy, 1);
    check("l1_mode", bus.mode, 1);

    // pkt_valid held outside the decision cycle, dropped before it: no island.
    wait_pos(12, 1);
    bus.pkt_valid = 1'b1;
    wait_pos(27, 1);
    bus.pkt_valid = 1'b0;
    tick();
    for (int i = 28; i <= 40; i++) begin
      check("offdec_mode", bus.mode, 0);
      check("offdec_ack",  bus.pkt_ack, 0);
      check("offdec_ctl",  bus.ctrl[5:2], 0);
      tick();
    end

    // Next line is blanking: no preamble.
    wait_pos(90, 1);
    check("nopre_ctl",  bus.ctrl[5:2], 0);
    check("nopre_mode", bus.mode, 0);

    // Sync bits on the vsync line.
    wait_pos(80, 2);
    for (int i = 80; i < 84; i++) begin
      check("sync_on", bus.ctrl[1:0], 2'b11);
      tick();
    end
    check("hs_off", bus.ctrl[0], 0);
    check("vs_on",  bus.ctrl[1], 1);
    check("sync_mode", bus.mode, 0);

    // Last blank line precedes active line 0: preamble present.
    wait_pos(90, 3);
    check("pre3_ctl",  bus.ctrl[5:2], 4'b0001);
    check("pre3_mode", bus.mode, 0);
    wait_pos(0, 0);
    check("wrap_mode", bus.mode, 1);

    // Island request at the decision cycle, withdrawn right after.
    wait_pos(27, 0);
    bus.pkt_valid = 1'b1;
    tick();
    bus.pkt_valid = 1'b0;
    check_island_line();

    // Reset in the middle of an island.
    wait_pos(27, 0);
    bus.pkt_valid = 1'b1;
    tick();
    bus.pkt_valid = 1'b0;
    wait_pos(50, 0);
    check("mid_mode", bus.mode, ISL ? 3 : 0);
    check("mid_idx",  bus.pkt_idx, ISL ? 12 : 0);
    #2 reset = 1'b1;
    #1;
    check("arst_cx",   bus.cx, 0);
    check("arst_cy",   bus.cy, 0);
    check("arst_mode", bus.mode, 0);
    check("arst_ctrl", bus.ctrl, 0);
    check("arst_ack",  bus.pkt_ack, 0);
    check("arst_idx",  bus.pkt_idx, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ack",  bus.pkt_ack, 0);
      check("hold_mode", bus.mode, 0);
    end
    reset = 1'b0;
    tick();
    check("rel2_cx",   bus.cx, 0);
    check("rel2_cy",   bus.cy, 0);
    check("rel2_mode", bus.mode, 1);
    check("rel2_ack",  bus.pkt_ack, 0);
    wait_pos(38, 0);
    check("post_mode", bus.mode, 0);
    check("post_ack",  bus.pkt_ack, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hdmi_period_scheduler.md
HDMI_PERIOD_SCHEDULER -- requirements
Module: hdmi_period_scheduler

Interface
REQ-001 Parameter H_ACTIVE, default 1280: active pixels per line.
REQ-002 Parameter H_TOTAL, default 1650: total pixels per line.
REQ-003 Parameter H_SYNC_START / H_SYNC_END, defaults 1390 / 1430: hsync asserted for cx in [start, end).
REQ-004 Parameter V_ACTIVE / V_TOTAL, defaults 720 / 750: active and total lines per frame.
REQ-005 Parameter V_SYNC_START / V_SYNC_END, defaults 725 / 730: vsync asserted for cy in [start, end).
REQ-006 Parameter SYNC_POL, default 1'b1: asserted level of hsync/vsync.
REQ-007 clk_pixel  in  1  pixel clock; one clock domain; reset is asynchronous, active-high.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 pkt_valid  in  1  packet source has a 32-cycle island packet ready.
REQ-010 mode  out  3  per-cycle TMDS period select: 0 control, 1 video, 2 video guard, 3 island, 4 island guard.
REQ-011 ctrl  out  6  {CTL3,CTL2,CTL1,CTL0,vsync,hsync}; channel 0 takes [1:0], channel 1 [3:2], channel 2 [5:4].
REQ-012 pkt_ack  out  1  one-cycle pulse: packet accepted into current island.
REQ-013 pkt_idx  out  5  island data character index 0..31.
REQ-014 cx / cy  out  11 / 10  current pixel and line counters.

Function
REQ-015 cx increments each cycle, wraps H_TOTAL-1 -> 0; cy increments on cx wrap, wraps V_TOTAL-1 -> 0.
REQ-016 All outputs registered; mode/ctrl/pkt_* correspond to the cx/cy value output in the same cycle.
REQ-017 States: CTRL, DI_PRE(8), DI_GL(2), DI_DATA(32), DI_GT(2), VID_PRE(8), VID_GUARD(2), VIDEO.
REQ-018 VIDEO: cy<V_ACTIVE and cx<H_ACTIVE; mode=1, CTL bits 0.
REQ-019 VID_PRE at cx H_TOTAL-10..H_TOTAL-3 when next line is active (cy+1 wrapped <V_ACTIVE); mode=0, CTL3..0=0001.
REQ-020 VID_GUARD at cx H_TOTAL-2..H_TOTAL-1; mode=2, CTL bits 0.
REQ-021 Island decision at cx==H_ACTIVE+11 on every line (active or blanking): sample pkt_valid; if 1, DI_PRE starts at cx==H_ACTIVE+12.
REQ-022 DI_PRE: mode=0, CTL3..0=0101; DI_GL and DI_GT: mode=4; DI_DATA: mode=3, pkt_idx 0..31.
REQ-023 pkt_ack high exactly the first DI_DATA cycle (pkt_idx=0); island completes even if pkt_valid drops after decision.
REQ-024 At most one island per line; pkt_valid outside the decision cycle has no effect.
REQ-025 hsync/vsync per REQ-003/005 with SYNC_POL, driven in every mode (consumed during control and island periods).
REQ-026 Elsewhere state CTRL: mode=0, CTL bits 0.
REQ-027 Parameter check: H_ACTIVE+12+44+12 <= H_TOTAL-10 else elaboration error.

Reset
REQ-028 reset asserted: cx=0, cy=0, state CTRL, mode=0, ctrl=0 (sync at SYNC_POL-inactive level), pkt_ack=0, pkt_idx=0, immediately regardless of clock.
REQ-029 Reset mid-island aborts without pkt_ack; first cycle after release is cx=0, cy=0, mode=1.

Configuration
REQ-030 Macro HDMI_DATA_ISLAND_EN defined: islands scheduled per REQ-021..024.
REQ-031 Macro undefined (DVI mode): no island states; pkt_ack, pkt_idx tied 0; mode never 3 or 4.

Verification (H_ACTIVE=16, H_TOTAL=100, H_SYNC 80..84, V_ACTIVE=2, V_TOTAL=4, V_SYNC 2..3, SYNC_POL=1)
REQ-032 Release reset -> cx=0,cy=0 mode=1 for cx 0..15; mode=0 at cx 16.
REQ-033 cy=0, no pkt_valid -> cx 90..97 ctrl[5:2]=0001 mode=0; cx 98..99 mode=2; cy=1 cx 0 mode=1.
REQ-034 cy=1 -> no video preamble at cx 90 (next line blank); cy=3 -> preamble present.
REQ-035 pkt_valid=1 at cx 27 -> cx 28..35 ctrl[5:2]=0101; cx 36..37 mode=4; cx 38..69 mode=3, pkt_idx 0..31, pkt_ack at cx 38 only; cx 70..71 mode=4.
REQ-036 Assert reset at cx 50 during island -> outputs zero immediately, no pkt_ack; after release cx=0 mode=1.
REQ-037 cy=2, cx 80..83 -> ctrl[0]=1, ctrl[1]=1; cx 84 -> ctrl[0]=0.
